// File: rtl/program_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : program_loader_if
// Description : Byte-stream handshake and memory write bus for program_loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface program_loader_if;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] address;
  logic [31:0] memIn;
  logic        write;

  // master: host bridge and memory side; slave: the loader itself
  modport master (
    output in_byte,
    output in_valid,
    input  in_ready,
    input  address,
    input  memIn,
    input  write
  );

  modport slave (
    input  in_byte,
    input  in_valid,
    output in_ready,
    output address,
    output memIn,
    output write
  );
endinterface
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Packs a host byte stream into little-endian 32-bit words and
//               writes them to word-aligned, incrementing memory addresses.
//               Optional trailing checksum word: PROGRAM_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader #(
  parameter int CNT_W = 16,
  parameter int DEBUG = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  program_loader_if.slave  bus,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      mem_data_q, mem_data_d;
  logic [23:0]      part_q, part_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] word_total_q, word_total_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [31:0]      sum_q, sum_d;
`endif

  logic             byte_accept;
  logic [23:0]      part_ins;
  logic [31:0]      full_word;
  logic [CNT_W-1:0] word_cnt_inc;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign bus.in_ready = (state_q == ST_RECV) || (state_q == ST_CHECK);
  assign busy         = (state_q == ST_RECV) || (state_q == ST_WRITE) || (state_q == ST_CHECK);
`else
  assign bus.in_ready = (state_q == ST_RECV);
  assign busy         = (state_q == ST_RECV) || (state_q == ST_WRITE);
`endif
  assign bus.write    = (state_q == ST_WRITE);
  assign bus.address  = addr_q;
  assign bus.memIn    = mem_data_q;
  assign done         = done_q;
  assign error        = error_q;

  assign byte_accept  = bus.in_valid && bus.in_ready;
  assign full_word    = {bus.in_byte, part_q};
  assign word_cnt_inc = word_cnt_q + 1'b1;

  // First byte of a word lands in the least significant lane
  always_comb begin
    part_ins = part_q;
    case (byte_idx_q)
      2'd0:    part_ins[7:0]   = bus.in_byte;
      2'd1:    part_ins[15:8]  = bus.in_byte;
      2'd2:    part_ins[23:16] = bus.in_byte;
      default: part_ins        = part_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    mem_data_d   = mem_data_q;
    part_d       = part_q;
    byte_idx_d   = byte_idx_q;
    word_cnt_d   = word_cnt_q;
    word_total_d = word_total_q;
    done_d       = done_q;
    error_d      = error_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sum_d        = sum_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (base_addr[1:0] != 2'b00) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            error_d = 1'b1;
          end else if (word_count == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            error_d = 1'b0;
          end else begin
            state_d      = ST_RECV;
            addr_d       = base_addr;
            part_d       = '0;
            byte_idx_d   = 2'd0;
            word_cnt_d   = '0;
            word_total_d = word_count;
            done_d       = 1'b0;
            error_d      = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_d        = '0;
`endif
          end
        end
      end

      ST_RECV: begin
        if (byte_accept) begin
          if (byte_idx_q == 2'd3) begin
            mem_data_d = full_word;
            part_d     = '0;
            byte_idx_d = 2'd0;
            state_d    = ST_WRITE;
          end else begin
            part_d     = part_ins;
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end

      ST_WRITE: begin
        addr_d     = addr_q + 32'd4;
        word_cnt_d = word_cnt_inc;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_d      = sum_q + mem_data_q;
`endif
        if (word_cnt_inc == word_total_q) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_d = ST_CHECK;
`else
          state_d = ST_DONE;
          done_d  = 1'b1;
          error_d = 1'b0;
`endif
        end else begin
          state_d = ST_RECV;
        end
      end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      // Trailing checksum word is compared, never written to memory
      ST_CHECK: begin
        if (byte_accept) begin
          if (byte_idx_q == 2'd3) begin
            part_d     = '0;
            byte_idx_d = 2'd0;
            done_d     = 1'b1;
            error_d    = (full_word != sum_q);
            state_d    = ST_DONE;
          end else begin
            part_d     = part_ins;
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      mem_data_q   <= '0;
      part_q       <= '0;
      byte_idx_q   <= '0;
      word_cnt_q   <= '0;
      word_total_q <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      mem_data_q   <= mem_data_d;
      part_q       <= part_d;
      byte_idx_q   <= byte_idx_d;
      word_cnt_q   <= word_cnt_d;
      word_total_q <= word_total_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  generate
    if (DEBUG != 0) begin : g_debug
`ifndef SYNTHESIS
      always_ff @(posedge clk) begin
        if (!reset && bus.write)
          $display("LDR: wrote %08h at %08h", bus.memIn, bus.address);
      end
`endif
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Table-driven session vectors plus hand-written reset/start
//               sequences for program_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        busy, done, error;

  program_loader_if lif ();

  program_loader #(.CNT_W(16), .DEBUG(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .bus        (lif.slave),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]       base;
    logic [15:0]       count;
    int                nbytes;
    logic [0:15][7:0]  bytes;
    bit                gap;
    bit                imm;
    bit                exp_err;
    int                exp_wr;
    logic [31:0]       a0, d0, a1, d1;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          wr_total = 0;
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  vec_t        vecs [8];
  int          nvec;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endfunction

  function automatic vec_t mk(logic [31:0] base, logic [15:0] count, int nbytes,
                              logic [127:0] bytes, bit gap, bit imm, bit err, int nwr,
                              logic [31:0] a0, logic [31:0] d0,
                              logic [31:0] a1, logic [31:0] d1);
    vec_t v;
    v.base = base; v.count = count; v.nbytes = nbytes; v.bytes = bytes;
    v.gap = gap; v.imm = imm; v.exp_err = err; v.exp_wr = nwr;
    v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
    return v;
  endfunction

  // Write monitor; a byte must never be accepted in a write cycle
  always @(negedge clk) begin
    if (lif.write) begin
      wr_addr[wr_total % 64] = lif.address;
      wr_data[wr_total % 64] = lif.memIn;
      wr_total++;
      chk("no_accept_during_write", 32'(lif.in_ready), 32'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input logic [31:0] b, input logic [15:0] c);
    base_addr  = b;
    word_count = c;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    lif.in_byte  = b;
    lif.in_valid = 1'b1;
    for (int t = 0; t < 20 && !ok; t++) begin
      if (lif.in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL send_byte_timeout: byte %02h never accepted", b);
    end
  endtask

  task automatic wait_done(input string name);
    for (int t = 0; t < 80 && !done; t++) @(negedge clk);
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL %s_done_timeout: done=%0b required 1", name, done);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int first;
    first = wr_total;
    do_start(v.base, v.count);
    @(negedge clk);
    if (v.imm) begin
      chk($sformatf("v%0d_imm_done", id), 32'(done), 32'd1);
      chk($sformatf("v%0d_imm_error", id), 32'(error), 32'(v.exp_err));
      chk($sformatf("v%0d_imm_busy", id), 32'(busy), 32'd0);
    end else begin
      chk($sformatf("v%0d_start_busy", id), 32'(busy), 32'd1);
      chk($sformatf("v%0d_start_done", id), 32'(done), 32'd0);
    end
    for (int k = 0; k < v.nbytes; k++) begin
      if (v.gap && k == 2) begin
        lif.in_valid = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk($sformatf("v%0d_gap_ready", id), 32'(lif.in_ready), 32'd1);
          @(posedge clk); #1;
        end
      end
      send_byte(v.bytes[k]);
    end
    lif.in_valid = 1'b0;
    wait_done($sformatf("v%0d", id));
    chk($sformatf("v%0d_error", id), 32'(error), 32'(v.exp_err));
    chk($sformatf("v%0d_busy_at_done", id), 32'(busy), 32'd0);
    chk($sformatf("v%0d_write_count", id), 32'(wr_total - first), 32'(v.exp_wr));
    if (v.exp_wr > 0) begin
      chk($sformatf("v%0d_addr0", id), wr_addr[first % 64], v.a0);
      chk($sformatf("v%0d_data0", id), wr_data[first % 64], v.d0);
    end
    if (v.exp_wr > 1) begin
      chk($sformatf("v%0d_addr1", id), wr_addr[(first + 1) % 64], v.a1);
      chk($sformatf("v%0d_data1", id), wr_data[(first + 1) % 64], v.d1);
    end
    if (!v.imm)
      chk($sformatf("v%0d_final_addr", id), lif.address, v.base + 32'(v.count) * 32'd4);
    @(posedge clk); #1;
  endtask

  initial begin
    int snap;
    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    lif.in_byte = '0; lif.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(lif.in_ready), 32'd0);
    chk("rst_write",    32'(lif.write),    32'd0);
    chk("rst_done",     32'(done),         32'd0);
    chk("rst_busy",     32'(busy),         32'd0);
    chk("rst_error",    32'(error),        32'd0);
    chk("rst_address",  lif.address,       32'd0);
    chk("rst_memIn",    lif.memIn,         32'd0);
    @(posedge clk); #1;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    vecs[0] = mk(32'h28, 16'd2, 12, {8'h13,8'h05,8'h50,8'h00, 8'hB3,8'h05,8'hB5,8'h00,
                 8'hC6,8'h0A,8'h05,8'h01, 32'h0}, 0, 0, 0, 2,
                 32'h28, 32'h00500513, 32'h2C, 32'h00B505B3);
    vecs[1] = mk(32'h28, 16'd2, 12, {8'h13,8'h05,8'h50,8'h00, 8'hB3,8'h05,8'hB5,8'h00,
                 8'hC6,8'h0A,8'h05,8'h01, 32'h0}, 1, 0, 0, 2,
                 32'h28, 32'h00500513, 32'h2C, 32'h00B505B3);
    vecs[4] = mk(32'hFFFFFFFC, 16'd2, 12, {8'h11,8'h22,8'h33,8'h44, 8'h55,8'h66,8'h77,8'h88,
                 8'h66,8'h88,8'hAA,8'hCC, 32'h0}, 0, 0, 0, 2,
                 32'hFFFFFFFC, 32'h44332211, 32'h00000000, 32'h88776655);
    vecs[5] = mk(32'h0, 16'd1, 8, {8'hEF,8'hBE,8'hAD,8'hDE, 8'hEF,8'hBE,8'hAD,8'hDE, 64'h0},
                 0, 0, 0, 1, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0);
    vecs[6] = mk(32'h200, 16'd2, 12, {8'h01,8'h00,8'h00,8'h00, 8'h02,8'h00,8'h00,8'h00,
                 8'h03,8'h00,8'h00,8'h00, 32'h0}, 0, 0, 0, 2,
                 32'h200, 32'h1, 32'h204, 32'h2);
    vecs[7] = mk(32'h200, 16'd2, 12, {8'h01,8'h00,8'h00,8'h00, 8'h02,8'h00,8'h00,8'h00,
                 8'h04,8'h00,8'h00,8'h00, 32'h0}, 0, 0, 1, 2,
                 32'h200, 32'h1, 32'h204, 32'h2);
    nvec = 8;
`else
    vecs[0] = mk(32'h28, 16'd2, 8, {8'h13,8'h05,8'h50,8'h00, 8'hB3,8'h05,8'hB5,8'h00, 64'h0},
                 0, 0, 0, 2, 32'h28, 32'h00500513, 32'h2C, 32'h00B505B3);
    vecs[1] = mk(32'h28, 16'd2, 8, {8'h13,8'h05,8'h50,8'h00, 8'hB3,8'h05,8'hB5,8'h00, 64'h0},
                 1, 0, 0, 2, 32'h28, 32'h00500513, 32'h2C, 32'h00B505B3);
    vecs[4] = mk(32'hFFFFFFFC, 16'd2, 8, {8'h11,8'h22,8'h33,8'h44, 8'h55,8'h66,8'h77,8'h88, 64'h0},
                 0, 0, 0, 2, 32'hFFFFFFFC, 32'h44332211, 32'h00000000, 32'h88776655);
    vecs[5] = mk(32'h0, 16'd1, 4, {8'hEF,8'hBE,8'hAD,8'hDE, 96'h0},
                 0, 0, 0, 1, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0);
    nvec = 6;
`endif
    vecs[2] = mk(32'h2A, 16'd2, 0, 128'h0, 0, 1, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    vecs[3] = mk(32'h40, 16'd0, 0, 128'h0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);

    for (int i = 0; i < nvec; i++) run_vec(vecs[i], i);

    // 3-word session: start while busy is ignored, then reset after 6 bytes
    snap = wr_total;
    do_start(32'h300, 16'd3);
    send_byte(8'h01);
    send_byte(8'h02);
    lif.in_valid = 1'b0;
    do_start(32'h500, 16'd1);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h05);
    send_byte(8'h06);
    lif.in_valid = 1'b0;
    chk("midrst_writes_before", 32'(wr_total - snap), 32'd1);
    chk("midrst_addr0", wr_addr[snap % 64], 32'h300);
    chk("midrst_data0", wr_data[snap % 64], 32'h04030201);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy",     32'(busy),         32'd0);
    chk("midrst_done",     32'(done),         32'd0);
    chk("midrst_in_ready", 32'(lif.in_ready), 32'd0);
    chk("midrst_address",  lif.address,       32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_more_writes", 32'(wr_total - snap), 32'd1);

    snap = wr_total;
    do_start(32'h100, 16'd1);
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    send_byte(8'hA4);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    send_byte(8'hA4);
`endif
    lif.in_valid = 1'b0;
    wait_done("fresh");
    chk("fresh_writes", 32'(wr_total - snap), 32'd1);
    chk("fresh_addr",   wr_addr[snap % 64],   32'h100);
    chk("fresh_data",   wr_data[snap % 64],   32'hA4A3A2A1);
    chk("fresh_error",  32'(error),           32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("done_held",    32'(done),            32'd1);
    chk("addr_held",    lif.address,          32'h104);
    chk("done_idle_ready", 32'(lif.in_ready), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
